vector_load_writeback: RTL and testbench

- Writeback stage directly upstream of the scalar/vector register file.
- Services a vector load by fetching I*L bits from the 32-bit data memory as consecutive words and packing them into one I-lane vector.
- Drives the register file write port (WE, A3_WB, WD3_SCA, WD3_VEC) and arbitrates that port between the vector load and ordinary scalar writebacks.

---
 rtl/vector_load_writeback_if.sv | 31 +++
 rtl/vector_load_writeback.sv | 106 ++++++++++
 tb/tb_vector_load_writeback.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_load_writeback_if.sv
// vector_load_writeback_if: request, memory and register-file write bundle for the vector load writeback stage
interface vector_load_writeback_if #(
  parameter int N = 32,
  parameter int I = 20,
  parameter int L = 8
);
  logic           req_valid;
  logic           req_ready;
  logic [N-1:0]   req_base;
  logic [4:0]     req_dest;
  logic           mem_re;
  logic [N-1:0]   mem_addr;
  logic [N-1:0]   mem_rdata;
  logic           sca_we;
  logic [4:0]     sca_addr;
  logic [N-1:0]   sca_data;
  logic           WE;
  logic [4:0]     A3_WB;
  logic [N-1:0]   WD3_SCA;
  logic [I*L-1:0] WD3_VEC;
  logic           busy;
  logic           err;
  modport master (
    output req_valid, req_base, req_dest, mem_rdata, sca_we, sca_addr, sca_data,
    input  req_ready, mem_re, mem_addr, WE, A3_WB, WD3_SCA, WD3_VEC, busy, err
  );
  modport slave (
    input  req_valid, req_base, req_dest, mem_rdata, sca_we, sca_addr, sca_data,
    output req_ready, mem_re, mem_addr, WE, A3_WB, WD3_SCA, WD3_VEC, busy, err
  );
endinterface

// File: rtl/vector_load_writeback.sv
// vector_load_writeback: fetches WORDS memory words into one lane-packed vector and arbitrates the register-file write port
module vector_load_writeback #(
  parameter int N = 32,
  parameter int I = 20,
  parameter int L = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  vector_load_writeback_if.slave bus
);
  localparam int WORDS = I * L / N;
  localparam int CW    = $clog2(WORDS + 1);
  if ((I * L) % N != 0) begin : g_bad_geometry
    $error("I*L must be a multiple of N");
  end
  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  issue_q, issue_d, cap_q;
  logic           pend_q;
  logic [N-1:0]   base_q;
  logic [4:0]     dest_q;
  logic [I*L-1:0] buf_q;
  logic           accept, dest_ok;
  assign accept  = state_q == IDLE && bus.req_valid;
  assign dest_ok = dest_q[4:3] == 2'b10;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      base_q  <= '0;
      dest_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      pend_q  <= bus.mem_re;
      cap_q   <= accept ? '0 : cap_q + CW'(pend_q);
      if (accept) begin
        base_q <= bus.req_base;
        dest_q <= bus.req_dest;
      end
      // read data lands one cycle after its strobe, so captures trail issues by one
      for (int w = 0; w < WORDS; w++)
        if (pend_q && cap_q == CW'(w)) buf_q[w*N +: N] <= bus.mem_rdata;
    end
  end
  always_comb begin
    state_d       = state_q;
    issue_d       = issue_q;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.err       = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.WE        = bus.sca_we;
    bus.A3_WB     = bus.sca_addr;
    bus.WD3_SCA   = bus.sca_data;
    bus.WD3_VEC   = buf_q;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = READ;
          issue_d = '0;
        end
      end
      READ: begin
        bus.busy     = 1'b1;
        bus.mem_re   = 1'b1;
        bus.mem_addr = base_q + (N'(issue_q) << 2);
        issue_d      = issue_q + 1'b1;
        state_d      = issue_q == CW'(WORDS - 1) ? DRAIN : READ;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        bus.busy = 1'b1;
        if (!dest_ok) begin
          bus.err = 1'b1;
          state_d = IDLE;
        end else if (!bus.sca_we) begin
          bus.WE      = 1'b1;
          bus.A3_WB   = dest_q;
          bus.WD3_SCA = '0;
          state_d     = IDLE;
        end
      end
    endcase
    // outputs go quiet the moment reset is applied, scalar pass-through included
    if (!rst_n) begin
      bus.req_ready = 1'b0;
      bus.busy      = 1'b0;
      bus.err       = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.WE        = 1'b0;
      bus.A3_WB     = '0;
      bus.WD3_SCA   = '0;
      bus.WD3_VEC   = '0;
    end
  end
endmodule

// File: tb/tb_vector_load_writeback.sv
// tb_vector_load_writeback: randomized and directed loads checked by a queue scoreboard against a word-level memory model
module tb_vector_load_writeback;
  localparam int N = 32;
  localparam int I = 20;
  localparam int L = 8;
  localparam int WORDS = I * L / N;
  localparam int V = I * L;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vector_load_writeback_if #(.N(N), .I(I), .L(L)) bus();
  vector_load_writeback #(.N(N), .I(I), .L(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [N-1:0] addr_q[$];
  logic [V-1:0] vec_q[$];
  logic [4:0]   vdest_q[$];
  logic [4:0]   err_q[$];
  logic [36:0]  sca_q[$];
  bit           dmode = 1'b1;
  logic [31:0]  dbase = 32'h100;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return dmode ? 32'hA0B0C0D0 + ((a - dbase) >> 2) : (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  always @(posedge clk) bus.mem_rdata <= bus.mem_re ? mem_word(bus.mem_addr) : $urandom;
  task automatic chk(string name, logic [V-1:0] act, logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask
  // reference: a load is WORDS consecutive words, word k filling vector bits [32k +: 32]
  task automatic expect_load(logic [31:0] base, logic [4:0] dest);
    logic [V-1:0] v;
    for (int k = 0; k < WORDS; k++) begin
      addr_q.push_back(base + 32'(4 * k));
      v[32*k +: 32] = mem_word(base + 32'(4 * k));
    end
    if (dest >= 5'd16 && dest <= 5'd23) begin
      vec_q.push_back(v);
      vdest_q.push_back(dest);
    end else err_q.push_back(dest);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.mem_re) begin
      if (addr_q.size() == 0) fail_now("unexpected_mem_re");
      else chk("mem_addr", bus.mem_addr, addr_q.pop_front());
    end
    if (bus.sca_we) begin
      if (sca_q.size() == 0) fail_now("unexpected_scalar");
      else begin
        logic [36:0] s;
        s = sca_q.pop_front();
        chk("sca_WE", bus.WE, 1'b1);
        chk("sca_A3", bus.A3_WB, s[36:32]);
        chk("sca_WD3", bus.WD3_SCA, s[31:0]);
      end
    end else if (bus.WE) begin
      if (vec_q.size() == 0) fail_now("unexpected_vec_write");
      else begin
        chk("vec_A3", bus.A3_WB, vdest_q.pop_front());
        chk("vec_data", bus.WD3_VEC, vec_q.pop_front());
        chk("vec_sca_zero", bus.WD3_SCA, '0);
      end
    end
    if (bus.err) begin
      if (err_q.size() == 0) fail_now("unexpected_err");
      else begin
        void'(err_q.pop_front());
        chk("err_no_vec_we", bus.WE, bus.sca_we);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_sca(bit we, logic [4:0] a, logic [31:0] d);
    bus.sca_we   = we;
    bus.sca_addr = a;
    bus.sca_data = d;
    if (we) sca_q.push_back({a, d});
  endtask
  task automatic step(int pct);
    tick();
    drive_sca(int'($urandom_range(99)) < pct, 5'($urandom), $urandom);
  endtask
  task automatic accept(logic [31:0] base, logic [4:0] dest, bit hold, int pct, output int acc);
    int b = 0;
    bus.req_base  = base;
    bus.req_dest  = dest;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && b < 200) begin
      step(pct);
      b++;
    end
    if (b == 200) fail_now("ready_timeout");
    expect_load(base, dest);
    step(pct);
    acc = cyc - 1;
    if (!hold) bus.req_valid = 1'b0;
  endtask
  task automatic drain(int pct);
    int b = 0;
    while (bus.busy && b < 200) begin
      step(pct);
      b++;
    end
    if (b == 200) fail_now("busy_timeout");
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, acc2;
    logic [31:0] wexp [WORDS];
    bus.req_valid = 1'b0;
    bus.req_base  = '0;
    bus.req_dest  = '0;
    drive_sca(1'b0, 5'd7, 32'hDEAD);
    bus.sca_we = 1'b1;
    #12;
    chk("rst_mem_re", bus.mem_re, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_WE", bus.WE, 1'b0);
    chk("rst_A3", bus.A3_WB, '0);
    chk("rst_WD3_SCA", bus.WD3_SCA, '0);
    chk("rst_WD3_VEC", bus.WD3_VEC, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    tick();
    bus.sca_we = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.req_ready, 1'b1);
    // basic load: latency table and explicit lanes
    accept(32'h100, 5'd16, 1'b0, 0, acc);
    for (int n = 1; n <= 8; n++) begin
      #1;
      chk("t1_mem_re", bus.mem_re, n <= 5);
      chk("t1_busy", bus.busy, n <= 7);
      chk("t1_WE", bus.WE, n == 7);
      chk("t1_ready", bus.req_ready, n == 8);
      if (n == 1) chk("t1_addr0", bus.mem_addr, 32'h100);
      if (n == 5) chk("t1_addr4", bus.mem_addr, 32'h110);
      if (n == 7) begin
        chk("t1_A3", bus.A3_WB, 5'd16);
        chk("t1_lane0", bus.WD3_VEC[7:0], 8'hD0);
        chk("t1_lane3", bus.WD3_VEC[31:24], 8'hA0);
        chk("t1_lane4", bus.WD3_VEC[39:32], 8'hD1);
        chk("t1_lane16", bus.WD3_VEC[135:128], 8'hD4);
        chk("t1_lane19", bus.WD3_VEC[159:152], 8'hA0);
      end
      step(0);
    end
    // scalar conflict in cycles 7-8 pushes the vector write to cycle 9
    accept(32'h100, 5'd16, 1'b0, 0, acc);
    for (int n = 1; n <= 10; n++) begin
      drive_sca(n == 7 || n == 8, 5'd3, 32'h55);
      #1;
      if (n == 7 || n == 8) begin
        chk("t2_sca_WE", bus.WE, 1'b1);
        chk("t2_sca_A3", bus.A3_WB, 5'd3);
        chk("t2_sca_WD3", bus.WD3_SCA, 32'h55);
      end
      if (n == 9) begin
        chk("t2_vec_WE", bus.WE, 1'b1);
        chk("t2_vec_A3", bus.A3_WB, 5'd16);
      end
      chk("t2_busy", bus.busy, n <= 9);
      tick();
    end
    drive_sca(1'b0, 5'd0, 32'h0);
    // non-vector destination
    accept(32'h100, 5'd5, 1'b0, 0, acc);
    for (int n = 1; n <= 8; n++) begin
      #1;
      chk("t3_err", bus.err, n == 7);
      chk("t3_WE", bus.WE, 1'b0);
      chk("t3_ready", bus.req_ready, n == 8);
      step(0);
    end
    // back-to-back with req_valid held
    accept(32'h200, 5'd17, 1'b1, 0, acc);
    accept(32'h300, 5'd18, 1'b0, 0, acc2);
    chk("t4_second_accept", 32'(acc2), 32'(acc + 8));
    #1;
    chk("t4_mem_re", bus.mem_re, 1'b1);
    chk("t4_addr", bus.mem_addr, 32'h300);
    drain(0);
    step(0);
    // asynchronous reset in cycle 3 of a load
    accept(32'h400, 5'd19, 1'b0, 0, acc);
    step(0);
    step(0);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_re", bus.mem_re, 1'b0);
    chk("t5_WE", bus.WE, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    addr_q.delete();
    vec_q.delete();
    vdest_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_ready", bus.req_ready, 1'b1);
    chk("t5_vec_zero", bus.WD3_VEC, '0);
    repeat (12) step(0);
    // address wrap
    dmode = 1'b0;
    wexp = '{32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    accept(32'hFFFFFFFC, 5'd20, 1'b0, 0, acc);
    for (int n = 0; n < WORDS; n++) begin
      #1;
      chk("t6_wrap_addr", bus.mem_addr, wexp[n]);
      step(0);
    end
    drain(0);
    step(0);
    // randomized loads with random scalar traffic
    repeat (40) begin
      logic [4:0] d;
      d = $urandom_range(9) == 0 ? 5'($urandom) : 5'(16 + $urandom_range(7));
      repeat ($urandom_range(2)) step(30);
      accept($urandom, d, 1'b0, 30, acc);
      drain(30);
    end
    step(0);
    step(0);
    chk("end_addr_q", addr_q.size(), 0);
    chk("end_vec_q", vec_q.size(), 0);
    chk("end_err_q", err_q.size(), 0);
    chk("end_sca_q", sca_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
